fifo_byte_serializer: RTL and testbench
=======================================

# fifo_byte_serializer

Downstream consumer of the `fifo` block. It pops WIDTH-bit words from the FIFO read port and emits each word as WIDTH/OUT_WIDTH narrower slices on a valid/ready output stream. It tags the final slice of every word. It sits between the FIFO and a byte-oriented sink such as a UART or SPI transmitter.

## Interface
Parameters:
- WIDTH, 32, FIFO word width; must equal the upstream `fifo` WIDTH.
- OUT_WIDTH, 8, output slice width. WIDTH % OUT_WIDTH != 0 is an elaboration error (`$error`).
- MSB_FIRST, 1, slice order: 1 = most-significant slice first, 0 = least-significant slice first.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- rdata  in  WIDTH  FIFO read data; valid the cycle after rd_en is asserted with empty_flag low.
- empty_flag  in  1  FIFO empty.
- rd_en  out  1  FIFO pop request; combinational from state, empty_flag and out_ready.
- out_data  out  OUT_WIDTH  current slice.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts the slice this cycle.
- out_last  out  1  out_data is the final slice of the current word.
- busy  out  1  a word is in flight (state != IDLE).

## Operation
- N = WIDTH/OUT_WIDTH. Slice counter `idx` is max($clog2(N),1) bits wide and counts 0..N-1.
- FSM states:
  - IDLE: rd_en = !empty_flag. If rd_en is asserted, go to FETCH.
  - FETCH: capture rdata into the shift register. Set idx = 0. Go to SHIFT. rd_en = 0.
  - SHIFT: out_valid = 1.
    - On handshake (out_valid && out_ready) with idx < N-1: shift the register by OUT_WIDTH (left if MSB_FIRST, right otherwise) and increment idx.
    - On handshake with idx == N-1: if !empty_flag, assert rd_en this cycle and go to FETCH; else go to IDLE.
- out_data is the top OUT_WIDTH bits of the shift register when MSB_FIRST=1, the bottom OUT_WIDTH bits otherwise.
- out_last = (state == SHIFT) && (idx == N-1).
- While out_valid && !out_ready, out_data, out_last and idx hold.
- rd_en is never asserted while empty_flag is high, so the block never underflows the FIFO.
- Degenerate N = 1: every slice has out_last = 1. The FSM is unchanged.

## Timing
- Reset values (asserted asynchronously): state = IDLE, out_valid = 0, out_last = 0, out_data = 0, rd_en = 0, busy = 0, shift register = 0, idx = 0.
- Latency from IDLE with empty_flag low at cycle t:
  - cycle t: rd_en high;
  - cycle t+1: FETCH;
  - cycle t+2: out_valid high with the first slice.
- Throughput: N slices per N+1 cycles with out_ready held high. There is exactly one bubble (FETCH) between words.
- empty_flag rising during SHIFT has no effect until the last-slice handshake.
- Reset mid-word: remaining slices are discarded and the block returns to IDLE. A pop issued in the cycle before reset is lost. Data loss on reset is accepted system behaviour.
- Reset deasserted: the first rd_en can occur in the first cycle after deassertion.
- out_ready is ignored outside SHIFT.

## Structure
- Shared package `fifo_pkg`:
  - `serializer_state_t` enum (IDLE, FETCH, SHIFT);
  - default WIDTH/DEPTH constants used by both `fifo` and this block.
- No sub-module. The FSM, counter and shift register live in one module of about 150 lines.
- Top-level integration is a `fifo_byte_serializer` instance wired directly to a `fifo` instance.

## Test plan
- Single word, MSB_FIRST = 1, out_ready = 1: write 32'hD4F40099 into the FIFO.
  - Required: out_data D4, F4, 00, 99 on consecutive cycles; out_last only on 99; exactly one rd_en pulse.
- Back-to-back words: write 32'h281B86C4 then 32'hBABABABA.
  - Required: 28, 1B, 86, C4, one bubble, BA ×4; out_last twice; empty_flag high at the end with no further rd_en.
- Backpressure: hold out_ready = 0 for 3 cycles on the second slice of 32'hD4F40099.
  - Required: out_data stays F4 with out_valid high; no slice is lost or duplicated.
- Empty FIFO after reset: empty_flag held high for 20 cycles.
  - Required: rd_en, out_valid and busy stay 0.
- Reset mid-word: assert rst after slice F4 of 32'hD4F40099 has been accepted.
  - Required: all outputs 0 immediately (asynchronous); after release, the next FIFO word is serialized from its first slice.
- MSB_FIRST = 0 with word 32'hD4F40099.
  - Required: out_data 99, 00, F4, D4; out_last on D4.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo block and its downstream byte serializer.
package fifo_pkg;

  localparam int FIFO_WIDTH    = 32;
  localparam int FIFO_DEPTH    = 16;
  localparam int SER_OUT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2
  } serializer_state_t;

  // Slice counter width; a single-slice word still needs a 1-bit counter.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_byte_serializer.sv
// Pops WIDTH-bit words from a fifo read port and emits them as OUT_WIDTH-bit
// slices on a valid/ready stream, flagging the final slice of each word.
module fifo_byte_serializer
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int OUT_WIDTH = SER_OUT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     rdata,
  input  logic                 empty_flag,
  output logic                 rd_en,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy
);

  localparam int N     = WIDTH / OUT_WIDTH;
  localparam int IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  generate
    if ((WIDTH % OUT_WIDTH) != 0) begin : g_bad_width
      $error("fifo_byte_serializer: WIDTH (%0d) is not a multiple of OUT_WIDTH (%0d)",
             WIDTH, OUT_WIDTH);
    end
  endgenerate

  serializer_state_t state;
  logic [WIDTH-1:0]  shreg;
  logic [WIDTH-1:0]  shreg_shifted;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_inc;
  logic              last_hs;

  assign idx_inc = idx + IDX_W'(1);
  assign last_hs = (state == SHIFT) && out_ready && (idx == LAST_IDX);

  // Held low during reset so an asserted rst can never pop the fifo.
  assign rd_en = !rst && !empty_flag && ((state == IDLE) || last_hs);

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign out_data      = shreg[WIDTH-1 -: OUT_WIDTH];
      assign shreg_shifted = shreg << OUT_WIDTH;
    end else begin : g_lsb_first
      assign out_data      = shreg[OUT_WIDTH-1:0];
      assign shreg_shifted = shreg >> OUT_WIDTH;
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty_flag) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end

        FETCH: begin
          shreg     <= rdata;
          idx       <= '0;
          state     <= SHIFT;
          out_valid <= 1'b1;
          out_last  <= (LAST_IDX == '0);
          busy      <= 1'b1;
        end

        SHIFT: begin
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              if (!empty_flag) begin
                state <= FETCH;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              shreg    <= shreg_shifted;
              idx      <= idx_inc;
              out_last <= (idx_inc == LAST_IDX);
            end
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Directed bench for fifo_byte_serializer: a queue models the fifo, and an
// MSB-first and an LSB-first instance run side by side on the same stimulus.
module tb_fifo_byte_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rdata = '0;
  logic        empty_flag = 1'b1;
  logic        out_ready = 1'b0;

  logic       rd_en,  rd_en_l;
  logic [7:0] data_m, data_l;
  logic       valid_m, valid_l, last_m, last_l, busy_m, busy_l;

  always #5 clk = ~clk;

  fifo_byte_serializer #(.WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .rdata(rdata), .empty_flag(empty_flag), .rd_en(rd_en),
    .out_data(data_m), .out_valid(valid_m), .out_ready(out_ready),
    .out_last(last_m), .busy(busy_m)
  );

  fifo_byte_serializer #(.WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .rdata(rdata), .empty_flag(empty_flag), .rd_en(rd_en_l),
    .out_data(data_l), .out_valid(valid_l), .out_ready(out_ready),
    .out_last(last_l), .busy(busy_l)
  );

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] exp_msb;
    logic [31:0] exp_lsb;
  } vec_t;

  vec_t vecs[7];

  int checks = 0;
  int errors = 0;

  logic [31:0] fq[$];
  logic        pop_seen = 1'b0;
  logic [7:0]  got_m[$], got_l[$];
  logic        got_lm[$], got_ll[$];
  int          got_cyc[$];
  int          cyc = 0, rd_count = 0, rd_cyc = -1, first_valid = -1, diverge = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clear();
    got_m.delete(); got_l.delete(); got_lm.delete(); got_ll.delete(); got_cyc.delete();
    rd_count = 0; rd_cyc = -1; first_valid = -1;
  endtask

  task automatic sample();
    if (rd_en) begin
      rd_count++;
      if (rd_cyc < 0) rd_cyc = cyc;
      check("rd_en_while_empty", 64'(empty_flag), 64'd0);
    end
    if (rd_en !== rd_en_l) diverge++;
    pop_seen = rd_en;
    if (valid_m && first_valid < 0) first_valid = cyc;
    if (valid_m && out_ready) begin
      got_m.push_back(data_m); got_lm.push_back(last_m); got_cyc.push_back(cyc);
    end
    if (valid_l && out_ready) begin
      got_l.push_back(data_l); got_ll.push_back(last_l);
    end
  endtask

  // One clock: fifo model reacts just after the edge, outputs sampled on the falling edge.
  task automatic cycle(input logic ready);
    @(posedge clk);
    #1;
    cyc++;
    if (pop_seen && fq.size() > 0) rdata = fq.pop_front();
    pop_seen   = 1'b0;
    empty_flag = (fq.size() == 0);
    out_ready  = ready;
    @(negedge clk);
    sample();
  endtask

  task automatic run_until(input int n, input int budget);
    for (int i = 0; i < budget && got_m.size() < n; i++) cycle(1'b1);
  endtask

  function automatic logic [63:0] stream(input bit lsb);
    logic [63:0] s = '0;
    if (lsb) foreach (got_l[i]) s = {s[55:0], got_l[i]};
    else     foreach (got_m[i]) s = {s[55:0], got_m[i]};
    return s;
  endfunction

  function automatic logic [63:0] lasts(input bit lsb);
    logic [63:0] s = '0;
    if (lsb) foreach (got_ll[i]) s = {s[62:0], got_ll[i]};
    else     foreach (got_lm[i]) s = {s[62:0], got_lm[i]};
    return s;
  endfunction

  function automatic logic [63:0] outs_vec();
    return 64'({rd_en, valid_m, last_m, busy_m, data_m, rd_en_l, valid_l, last_l, busy_l, data_l});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls, bad;
    logic r;

    vecs[0] = '{32'hD4F40099, 32'hD4F40099, 32'h9900F4D4};
    vecs[1] = '{32'h281B86C4, 32'h281B86C4, 32'hC4861B28};
    vecs[2] = '{32'hBABABABA, 32'hBABABABA, 32'hBABABABA};
    vecs[3] = '{32'h00000000, 32'h00000000, 32'h00000000};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[5] = '{32'h12345678, 32'h12345678, 32'h78563412};
    vecs[6] = '{32'hA5C30F81, 32'hA5C30F81, 32'h810FC3A5};

    // Reset state, including rd_en held low while rst is high and data is pending.
    repeat (2) @(negedge clk);
    check("reset_outputs", outs_vec(), 64'd0);
    empty_flag = 1'b0;
    #1;
    check("reset_rd_en_gated", 64'({rd_en, rd_en_l}), 64'd0);
    empty_flag = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    sample();

    // Empty fifo for 20 cycles: nothing moves.
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1);
      if (rd_en || valid_m || busy_m || valid_l || busy_l) bad++;
    end
    check("empty_idle_activity", 64'(bad), 64'd0);
    check("empty_idle_rd_count", 64'(rd_count), 64'd0);

    // Single words, out_ready held high.
    foreach (vecs[i]) begin
      clear();
      fq.push_back(vecs[i].word);
      run_until(4, 20);
      repeat (3) cycle(1'b1);
      check($sformatf("vec%0d_slice_count", i), 64'(got_m.size()), 64'd4);
      check($sformatf("vec%0d_msb_seq", i), stream(0), 64'(vecs[i].exp_msb));
      check($sformatf("vec%0d_lsb_seq", i), stream(1), 64'(vecs[i].exp_lsb));
      check($sformatf("vec%0d_msb_last", i), lasts(0), 64'b0001);
      check($sformatf("vec%0d_lsb_last", i), lasts(1), 64'b0001);
      check($sformatf("vec%0d_rd_pulses", i), 64'(rd_count), 64'd1);
      check($sformatf("vec%0d_latency", i), 64'(first_valid - rd_cyc), 64'd2);
      if (got_cyc.size() == 4)
        check($sformatf("vec%0d_span", i), 64'(got_cyc[3] - got_cyc[0]), 64'd3);
      check($sformatf("vec%0d_idle_after", i), 64'({busy_m, valid_m, busy_l}), 64'd0);
    end

    // Back-to-back words: one FETCH bubble between them.
    clear();
    fq.push_back(32'h281B86C4);
    fq.push_back(32'hBABABABA);
    run_until(8, 30);
    repeat (5) cycle(1'b1);
    check("b2b_slice_count", 64'(got_m.size()), 64'd8);
    check("b2b_msb_seq", stream(0), 64'h281B86C4_BABABABA);
    check("b2b_lsb_seq", stream(1), 64'hC4861B28_BABABABA);
    check("b2b_last_pattern", lasts(0), 64'b0001_0001);
    if (got_cyc.size() == 8) begin
      check("b2b_bubble", 64'(got_cyc[4] - got_cyc[3]), 64'd2);
      check("b2b_span", 64'(got_cyc[7] - got_cyc[0]), 64'd8);
    end
    check("b2b_rd_pulses", 64'(rd_count), 64'd2);
    check("b2b_end_state", 64'({empty_flag, busy_m, rd_en}), 64'b100);

    // Backpressure: stall three cycles on the second slice.
    clear();
    fq.push_back(32'hD4F40099);
    stalls = 0;
    bad    = 0;
    for (int i = 0; i < 30 && got_m.size() < 4; i++) begin
      r = !(got_m.size() == 1 && stalls < 3);
      cycle(r);
      if (!r) begin
        stalls++;
        if (!(valid_m && data_m == 8'hF4 && !last_m)) bad++;
        if (!(valid_l && data_l == 8'h00 && !last_l)) bad++;
      end
    end
    repeat (3) cycle(1'b1);
    check("bp_stalls", 64'(stalls), 64'd3);
    check("bp_hold", 64'(bad), 64'd0);
    check("bp_msb_seq", stream(0), 64'hD4F40099);
    check("bp_lsb_seq", stream(1), 64'h9900F4D4);
    check("bp_last_pattern", lasts(0), 64'b0001);
    if (got_cyc.size() == 4)
      check("bp_span", 64'(got_cyc[3] - got_cyc[0]), 64'd6);

    // Reset mid-word after F4 is accepted; the next fifo word starts fresh.
    clear();
    fq.push_back(32'hD4F40099);
    fq.push_back(32'h12345678);
    run_until(2, 20);
    check("mid_pre_reset_seq", stream(0), 64'hD4F4);
    #2;
    rst = 1'b1;
    #1;
    check("mid_reset_outputs", outs_vec(), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear();
    #1;
    sample();
    run_until(4, 20);
    repeat (3) cycle(1'b1);
    check("mid_after_msb_seq", stream(0), 64'h12345678);
    check("mid_after_lsb_seq", stream(1), 64'h78563412);
    check("mid_after_last", lasts(0), 64'b0001);
    check("mid_after_rd_pulses", 64'(rd_count), 64'd1);
    check("mid_after_latency", 64'(first_valid - rd_cyc), 64'd2);

    check("rd_en_instances_agree", 64'(diverge), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
